// File: rtl/sa_pkg.sv
// Shared types for the systolic-array tile loader: element/matrix types, loader states
// and the X transpose+rotate the array expects on its X input.
package sa_pkg;

  localparam int PKG_D_W  = 8;
  localparam int PKG_SA_R = 16;
  localparam int PKG_SA_C = 16;
  localparam int ROW_AW   = $clog2(PKG_SA_R);

  typedef logic [PKG_D_W-1:0] elem_t;
  typedef elem_t [0:PKG_SA_R-1][0:PKG_SA_C-1] mat_t;

  typedef enum logic [2:0] {FILL_X, FILL_W, WAIT_SA, ISSUE, DRAIN} ldr_state_e;

  // X_ROT[i][j] = X[SA_C-1-j][i]
  function automatic mat_t rotate_x(input mat_t x);
    mat_t r;
    for (int i = 0; i < PKG_SA_R; i++) begin
      for (int j = 0; j < PKG_SA_C; j++) begin
        r[i][j] = x[PKG_SA_C-1-j][i];
      end
    end
    return r;
  endfunction

endpackage

// File: rtl/sa_tile_loader_if.sv
// Row-stream input, SA handshake and matrix outputs of the tile loader.
// slave = loader side, master = feeder/SA side.
interface sa_tile_loader_if;
  import sa_pkg::*;

  logic                         I_ROW_VLD;
  logic                         O_ROW_RDY;
  logic [PKG_SA_C*PKG_D_W-1:0]  I_ROW_DATA;
  logic                         I_TILE_ACC;
  logic                         I_SA_LOAD_RDY;
  logic                         I_SA_DONE;
  logic                         O_LOAD_FLAG;
  mat_t                         O_X_MATRIX;
  mat_t                         O_W_MATRIX;
  logic                         O_ACCUMULATE;
  logic [15:0]                  O_TILE_CNT;

  modport slave (
    input  I_ROW_VLD, I_ROW_DATA, I_TILE_ACC, I_SA_LOAD_RDY, I_SA_DONE,
    output O_ROW_RDY, O_LOAD_FLAG, O_X_MATRIX, O_W_MATRIX, O_ACCUMULATE, O_TILE_CNT
  );

  modport master (
    output I_ROW_VLD, I_ROW_DATA, I_TILE_ACC, I_SA_LOAD_RDY, I_SA_DONE,
    input  O_ROW_RDY, O_LOAD_FLAG, O_X_MATRIX, O_W_MATRIX, O_ACCUMULATE, O_TILE_CNT
  );

endinterface

// File: rtl/sa_row_buffer.sv
// Matrix staging buffer: one row written per beat, whole matrix readable at once.
// Element j of a row arrives at i_wdata[j*D_W +: D_W].
module sa_row_buffer
  import sa_pkg::*;
(
  input  logic                        I_CLK,
  input  logic                        i_we,
  input  logic [ROW_AW-1:0]           i_waddr,
  input  logic [PKG_SA_C*PKG_D_W-1:0] i_wdata,
  output mat_t                        o_mat
);

  generate
    for (genvar gi = 0; gi < PKG_SA_R; gi++) begin : g_row
      elem_t [0:PKG_SA_C-1] r_row;

      always_ff @(posedge I_CLK) begin
        if (i_we && i_waddr == ROW_AW'(gi)) begin
          for (int j = 0; j < PKG_SA_C; j++) begin
            r_row[j] <= i_wdata[j*PKG_D_W +: PKG_D_W];
          end
        end
      end

      assign o_mat[gi] = r_row;
    end
  endgenerate

endmodule

// File: rtl/sa_tile_loader.sv
// Collects one X and one W tile as a row stream, rotates X and issues a one-cycle load to the SA.
// SA_LOADER_OVERLAP_EN: when defined, the next tile fills while the SA runs (no DRAIN state).
module sa_tile_loader
  import sa_pkg::*;
#(
  parameter int D_W  = PKG_D_W,
  parameter int SA_R = PKG_SA_R,
  parameter int SA_C = PKG_SA_C
) (
  input  logic             I_CLK,
  input  logic             I_RST_N,
  sa_tile_loader_if.slave  bus
);

  generate
    if (SA_R != SA_C) begin : g_bad_shape
      $error("sa_tile_loader: SA_R must equal SA_C");
    end
    if (D_W != PKG_D_W || SA_R != PKG_SA_R || SA_C != PKG_SA_C) begin : g_bad_pkg
      $error("sa_tile_loader: parameters must match sa_pkg sizes");
    end
  endgenerate

  ldr_state_e         r_state;
  ldr_state_e         w_state_next;
  logic [ROW_AW-1:0]  r_row_cnt;
  logic               r_acc_l;
  logic               r_load_flag;
  mat_t               r_x_mat;
  mat_t               r_w_mat;
  logic               r_acc_out;
  logic [15:0]        r_tile_cnt;
  mat_t               w_xbuf;
  mat_t               w_wbuf;
  logic               w_row_rdy;
  logic               w_beat;
  logic               w_last;
  logic               w_issue;

  assign w_row_rdy = I_RST_N && (r_state == FILL_X || r_state == FILL_W);
  assign w_beat    = bus.I_ROW_VLD && w_row_rdy;
  assign w_last    = (r_row_cnt == ROW_AW'(PKG_SA_R - 1));
  assign w_issue   = (r_state == WAIT_SA) && bus.I_SA_LOAD_RDY;

  sa_row_buffer u_xbuf (
    .I_CLK   (I_CLK),
    .i_we    (w_beat && r_state == FILL_X),
    .i_waddr (r_row_cnt),
    .i_wdata (bus.I_ROW_DATA),
    .o_mat   (w_xbuf)
  );

  sa_row_buffer u_wbuf (
    .I_CLK   (I_CLK),
    .i_we    (w_beat && r_state == FILL_W),
    .i_waddr (r_row_cnt),
    .i_wdata (bus.I_ROW_DATA),
    .o_mat   (w_wbuf)
  );

  always_comb begin
    w_state_next = r_state;
    case (r_state)
      FILL_X:  if (w_beat && w_last) w_state_next = FILL_W;
      FILL_W:  if (w_beat && w_last) w_state_next = WAIT_SA;
      WAIT_SA: if (bus.I_SA_LOAD_RDY) w_state_next = ISSUE;
`ifdef SA_LOADER_OVERLAP_EN
      ISSUE:   w_state_next = FILL_X;
`else
      ISSUE:   w_state_next = DRAIN;
      DRAIN:   if (bus.I_SA_DONE) w_state_next = FILL_X;
`endif
      default: w_state_next = FILL_X;
    endcase
  end

`ifdef SA_LOADER_OVERLAP_EN
  logic w_unused_done;
  assign w_unused_done = bus.I_SA_DONE;
`endif

  // Output matrices are separate from the staging buffers, so they hold through the SA run.
  always_ff @(posedge I_CLK) begin
    if (!I_RST_N) begin
      r_state     <= FILL_X;
      r_row_cnt   <= '0;
      r_acc_l     <= 1'b0;
      r_load_flag <= 1'b0;
      r_x_mat     <= '0;
      r_w_mat     <= '0;
      r_acc_out   <= 1'b0;
      r_tile_cnt  <= '0;
    end else begin
      r_state     <= w_state_next;
      r_load_flag <= w_issue;
      if (w_beat) begin
        r_row_cnt <= w_last ? '0 : r_row_cnt + ROW_AW'(1);
        if (r_state == FILL_X && r_row_cnt == '0) begin
          r_acc_l <= bus.I_TILE_ACC;
        end
      end
      if (w_issue) begin
        r_x_mat    <= rotate_x(w_xbuf);
        r_w_mat    <= w_wbuf;
        r_acc_out  <= r_acc_l;
        r_tile_cnt <= r_tile_cnt + 16'd1;
      end
    end
  end

  assign bus.O_ROW_RDY    = w_row_rdy;
  assign bus.O_LOAD_FLAG  = r_load_flag;
  assign bus.O_X_MATRIX   = r_x_mat;
  assign bus.O_W_MATRIX   = r_w_mat;
  assign bus.O_ACCUMULATE = r_acc_out;
  assign bus.O_TILE_CNT   = r_tile_cnt;

endmodule

// File: tb/tb_sa_tile_loader.sv
// Bench for sa_tile_loader: table of tile scenarios plus hand-written reset/drain/wrap sequences,
// checked against a plain-array model of the expected SA inputs.
module tb_sa_tile_loader;

  localparam int N = 16;

  typedef struct {
    int delay;      // cycles I_SA_LOAD_RDY stays low after the tile is complete
    bit bp;         // random idle gaps between beats
    bit acc_first;  // I_TILE_ACC on the first X beat (later X beats get the inverse)
    bit exp_acc;    // expected O_ACCUMULATE at issue
    bit directed;   // fixed pattern instead of random data
  } vec_t;

  logic clk = 1'b0;
  logic rst_n;
  always #5 clk = ~clk;

  sa_tile_loader_if bus();

  sa_tile_loader #(.D_W(8), .SA_R(16), .SA_C(16)) dut (
    .I_CLK   (clk),
    .I_RST_N (rst_n),
    .bus     (bus)
  );

  int          n_checks = 0;
  int          n_errors = 0;
  int          tile_no  = 0;
  logic [7:0]  xm [N][N];
  logic [7:0]  wm [N][N];
  logic [7:0]  ex_x [N][N];
  logic [7:0]  ex_w [N][N];
  logic        exp_acc;
  logic [15:0] exp_cnt;
  vec_t        tbl [5];

  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
    n_checks++;
    if (act !== exp) begin
      n_errors++;
      $display("FAIL %s: got 0x%0h, expected 0x%0h", name, act, exp);
    end
  endtask

  task automatic model_reset();
    for (int i = 0; i < N; i++)
      for (int j = 0; j < N; j++) begin
        ex_x[i][j] = 8'h00;
        ex_w[i][j] = 8'h00;
      end
    exp_acc = 1'b0;
    exp_cnt = 16'h0000;
  endtask

  task automatic chk_outputs(input string tag);
    int bad_x = 0, bad_w = 0, bi = 0, bj = 0;
    logic [7:0] ga = 8'h00, ea = 8'h00;
    for (int i = 0; i < N; i++)
      for (int j = 0; j < N; j++) begin
        if (bus.O_X_MATRIX[i][j] !== ex_x[i][j]) begin
          if (bad_x == 0) begin bi = i; bj = j; ga = bus.O_X_MATRIX[i][j]; ea = ex_x[i][j]; end
          bad_x++;
        end
        if (bus.O_W_MATRIX[i][j] !== ex_w[i][j]) bad_w++;
      end
    n_checks += 2;
    if (bad_x != 0) begin
      n_errors++;
      $display("FAIL %s_x_matrix: %0d elements differ, [%0d][%0d] got 0x%0h expected 0x%0h",
               tag, bad_x, bi, bj, ga, ea);
    end
    if (bad_w != 0) begin
      n_errors++;
      $display("FAIL %s_w_matrix: got %0d differing elements, expected 0", tag, bad_w);
    end
    chk({tag, "_acc"}, 32'(bus.O_ACCUMULATE), 32'(exp_acc));
    chk({tag, "_cnt"}, 32'(bus.O_TILE_CNT), 32'(exp_cnt));
  endtask

  function automatic logic [127:0] rnd128();
    logic [127:0] v;
    for (int k = 0; k < 4; k++) v[k*32 +: 32] = $urandom;
    return v;
  endfunction

  function automatic logic [127:0] pack_row(input int r, input bit is_w);
    logic [127:0] d;
    for (int j = 0; j < N; j++) d[j*8 +: 8] = is_w ? wm[r][j] : xm[r][j];
    return d;
  endfunction

  task automatic send_row(input logic [127:0] d, input logic acc, input bit bp);
    int guard = 0;
    int gaps;
    if (bp) begin
      gaps = $urandom_range(0, 3);
      for (int g = 0; g < gaps; g++) begin
        bus.I_ROW_VLD  = 1'b0;
        bus.I_ROW_DATA = rnd128();
        bus.I_TILE_ACC = 1'($urandom_range(0, 1));
        tick();
      end
    end
    bus.I_ROW_VLD  = 1'b1;
    bus.I_ROW_DATA = d;
    bus.I_TILE_ACC = acc;
    while (bus.O_ROW_RDY !== 1'b1 && guard < 200) begin
      tick();
      guard++;
    end
    if (guard >= 200) begin
      n_checks++;
      n_errors++;
      $display("FAIL row_accept_timeout: O_ROW_RDY got 0 for 200 cycles, expected 1");
    end
    tick();
    bus.I_ROW_VLD = 1'b0;
  endtask

  task automatic run_tile(input vec_t v, input bit skip_done);
    int base;
    for (int r = 0; r < N; r++) begin
      base = (r == 0) ? 'h10 : (r == 1) ? 'h11 : r;
      for (int j = 0; j < N; j++) begin
        xm[r][j] = v.directed ? 8'(base + 16 * j) : 8'($urandom);
        wm[r][j] = v.directed ? 8'(base + 16 * j) : 8'($urandom);
      end
    end
    bus.I_SA_LOAD_RDY = (v.delay == 0);
    for (int r = 0; r < N; r++) send_row(pack_row(r, 0), (r == 0) ? v.acc_first : !v.acc_first, v.bp);
    for (int r = 0; r < N; r++) send_row(pack_row(r, 1), 1'($urandom_range(0, 1)), v.bp);
    chk_outputs("pre_issue");
    for (int c = 0; c < v.delay; c++) begin
      chk("hold_flag", 32'(bus.O_LOAD_FLAG), 32'd0);
      chk("hold_rdy", 32'(bus.O_ROW_RDY), 32'd0);
      tick();
    end
    bus.I_SA_LOAD_RDY = 1'b1;
    tick();
    bus.I_SA_LOAD_RDY = 1'b0;
    chk("load_flag", 32'(bus.O_LOAD_FLAG), 32'd1);
    for (int i = 0; i < N; i++)
      for (int j = 0; j < N; j++) begin
        ex_x[i][j] = xm[N-1-j][i];
        ex_w[i][j] = wm[i][j];
      end
    exp_acc = v.exp_acc;
    exp_cnt = exp_cnt + 16'd1;
    chk_outputs("issue");
    tile_no++;
    $display("tile %0d: load issued, cnt=%0d acc=%0b delay=%0d bp=%0b",
             tile_no, bus.O_TILE_CNT, bus.O_ACCUMULATE, v.delay, v.bp);
    tick();
    chk("flag_width", 32'(bus.O_LOAD_FLAG), 32'd0);
    chk_outputs("after_issue");
    if (!skip_done) begin
      bus.I_SA_DONE = 1'b1;
      tick();
      bus.I_SA_DONE = 1'b0;
    end
  endtask

  initial begin
    #2000000;
    $display("FAIL watchdog: simulation still running at time limit, expected to finish");
    $fatal(1, "watchdog expired");
  end

  initial begin
    vec_t v;
    tbl[0] = '{delay: 0,  bp: 1'b0, acc_first: 1'b0, exp_acc: 1'b0, directed: 1'b1};
    tbl[1] = '{delay: 20, bp: 1'b0, acc_first: 1'b0, exp_acc: 1'b0, directed: 1'b0};
    tbl[2] = '{delay: 0,  bp: 1'b1, acc_first: 1'b0, exp_acc: 1'b0, directed: 1'b0};
    tbl[3] = '{delay: 3,  bp: 1'b1, acc_first: 1'b1, exp_acc: 1'b1, directed: 1'b0};
    tbl[4] = '{delay: 0,  bp: 1'b0, acc_first: 1'b1, exp_acc: 1'b1, directed: 1'b0};

    rst_n             = 1'b0;
    bus.I_ROW_VLD     = 1'b1;
    bus.I_ROW_DATA    = rnd128();
    bus.I_TILE_ACC    = 1'b0;
    bus.I_SA_LOAD_RDY = 1'b0;
    bus.I_SA_DONE     = 1'b0;
    model_reset();
    repeat (3) tick();
    chk("reset_rdy", 32'(bus.O_ROW_RDY), 32'd0);
    chk("reset_flag", 32'(bus.O_LOAD_FLAG), 32'd0);
    chk_outputs("reset");
    bus.I_ROW_VLD = 1'b0;
    rst_n = 1'b1;
    tick();
    chk("rdy_after_reset", 32'(bus.O_ROW_RDY), 32'd1);

    for (int t = 0; t < 5; t++) run_tile(tbl[t], 1'b0);

    // Second tile offered straight after an issue
    v = '{delay: 0, bp: 1'b0, acc_first: 1'b0, exp_acc: 1'b0, directed: 1'b0};
    run_tile(v, 1'b1);
`ifndef SA_LOADER_OVERLAP_EN
    chk("drain_rdy", 32'(bus.O_ROW_RDY), 32'd0);
    bus.I_ROW_VLD  = 1'b1;
    bus.I_ROW_DATA = rnd128();
    for (int c = 0; c < 10; c++) begin
      tick();
      chk("drain_hold_rdy", 32'(bus.O_ROW_RDY), 32'd0);
    end
    bus.I_SA_DONE = 1'b1;
    tick();
    bus.I_SA_DONE = 1'b0;
    bus.I_ROW_VLD = 1'b0;
    chk("rdy_after_done", 32'(bus.O_ROW_RDY), 32'd1);
    v.delay = 0;
`else
    chk("overlap_rdy", 32'(bus.O_ROW_RDY), 32'd1);
    v.delay = 6;
`endif
    run_tile(v, 1'b0);

    // Reset in the middle of an X tile
    bus.I_SA_LOAD_RDY = 1'b0;
    for (int r = 0; r < 7; r++) send_row(rnd128(), 1'b1, 1'b0);
    rst_n = 1'b0;
    #1;
    chk("midtile_reset_rdy", 32'(bus.O_ROW_RDY), 32'd0);
    tick();
    tick();
    model_reset();
    chk("midtile_reset_flag", 32'(bus.O_LOAD_FLAG), 32'd0);
    chk_outputs("midtile_reset");
    rst_n = 1'b1;
    tick();
    v = '{delay: 0, bp: 1'b1, acc_first: 1'b0, exp_acc: 1'b0, directed: 1'b0};
    run_tile(v, 1'b0);
    chk("clean_tile_cnt", 32'(bus.O_TILE_CNT), 32'd1);

    // Tile counter wrap from a preloaded 0xFFFF
    force dut.r_tile_cnt = 16'hFFFF;
    #1;
    release dut.r_tile_cnt;
    exp_cnt = 16'hFFFF;
    v = '{delay: 2, bp: 1'b0, acc_first: 1'b1, exp_acc: 1'b1, directed: 1'b0};
    run_tile(v, 1'b0);
    chk("wrap_cnt", 32'(bus.O_TILE_CNT), 32'd0);

    $display("Simulation finished: %0d checks, %0d errors", n_checks, n_errors);
    $finish;
  end

endmodule
